// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that serialises NPORTS requesters onto the SDRAM init/write/read/refresh engines.
// Optional auto-refresh scheduling is compiled in when SDRAM_ARB_REFRESH_EN is defined.
module sdram_port_arbiter #(
  parameter int NPORTS           = 4,
  parameter int ADDR_W           = 25,
  parameter int DATA_W           = 128,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic                       iclk,
  input  logic                       ireset_n,
  input  logic [NPORTS-1:0]          ireq,
  input  logic [NPORTS-1:0]          iwe,
  input  logic [NPORTS*ADDR_W-1:0]   iaddr,
  input  logic [NPORTS*DATA_W-1:0]   iwdata,
  output logic [NPORTS-1:0]          oack,
  output logic [DATA_W-1:0]          ordata,
  output logic                       oinit_req,
  output logic                       owr_req,
  output logic                       ord_req,
  output logic                       oref_req,
  output logic [3:0]                 osel,
  output logic [ADDR_W-1:0]          oaddr,
  output logic [DATA_W-1:0]          owdata,
  input  logic                       iinit_fin,
  input  logic                       iwr_fin,
  input  logic                       ird_fin,
  input  logic                       iref_fin,
  input  logic [DATA_W-1:0]          ird_data
);

  localparam int IDXW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NPORTS - 1);
  localparam logic [3:0] SEL_INIT = 4'b0001;
  localparam logic [3:0] SEL_WR   = 4'b0010;
  localparam logic [3:0] SEL_RD   = 4'b0100;
  localparam logic [3:0] SEL_REF  = 4'b1000;

  typedef enum logic [2:0] {
    S_INIT_REQ  = 3'd0,
    S_INIT_WAIT = 3'd1,
    S_IDLE      = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT      = 3'd4,
    S_ACK       = 3'd5,
    S_REF_ISSUE = 3'd6,
    S_REF_WAIT  = 3'd7
  } state_e;

  state_e              state_q;
  logic                armed_q;
  logic [IDXW-1:0]     last_q;
  logic                dir_we_q;
  logic [ADDR_W-1:0]   oaddr_q;
  logic [DATA_W-1:0]   owdata_q;
  logic [DATA_W-1:0]   ordata_q;
  logic [NPORTS-1:0]   oack_q;
  logic                oinit_q;
  logic                owr_q;
  logic                ord_q;
  logic [3:0]          osel_q;
  logic                gnt_valid_s;
  logic [IDXW-1:0]     gnt_idx_s;
  logic [IDXW-1:0]     scan_s;

  // Round-robin search starting one past the last granted port
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = last_q;
    scan_s      = last_q;
    for (int k = 1; k <= NPORTS; k++) begin
      scan_s = IDXW'((int'(last_q) + k) % NPORTS);
      if (!gnt_valid_s && ireq[scan_s]) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = scan_s;
      end else begin
        gnt_valid_s = gnt_valid_s;
      end
    end
  end

`ifdef SDRAM_ARB_REFRESH_EN
  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam logic [TW-1:0] REF_RELOAD = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0] ref_timer_q;
  logic          ref_pending_q;
  logic          oref_q;

  // Refresh interval timer; frozen until the init sequence completes
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      ref_timer_q   <= REF_RELOAD;
      ref_pending_q <= 1'b0;
    end else if (state_q == S_INIT_REQ || state_q == S_INIT_WAIT) begin
      ref_timer_q   <= REF_RELOAD;
      ref_pending_q <= 1'b0;
    end else begin
      if (state_q == S_REF_ISSUE) begin
        ref_pending_q <= 1'b0;
      end
      // An expiry in the issue cycle re-arms the flag rather than being lost
      if (ref_timer_q == {TW{1'b0}}) begin
        ref_timer_q   <= REF_RELOAD;
        ref_pending_q <= 1'b1;
      end else begin
        ref_timer_q <= ref_timer_q - TW'(1);
      end
    end
  end

  assign oref_req = oref_q;
`else
  logic unused_s;
  assign unused_s = iref_fin | (REFRESH_INTERVAL < 16);
  assign oref_req = 1'b0;
`endif

  // Main sequencer; every engine-facing output is registered here
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q  <= S_INIT_REQ;
      armed_q  <= 1'b0;
      last_q   <= LAST_RST;
      dir_we_q <= 1'b0;
      oaddr_q  <= {ADDR_W{1'b0}};
      owdata_q <= {DATA_W{1'b0}};
      ordata_q <= {DATA_W{1'b0}};
      oack_q   <= {NPORTS{1'b0}};
      oinit_q  <= 1'b0;
      owr_q    <= 1'b0;
      ord_q    <= 1'b0;
      osel_q   <= SEL_INIT;
`ifdef SDRAM_ARB_REFRESH_EN
      oref_q   <= 1'b0;
`endif
    end else begin
      oinit_q <= 1'b0;
      owr_q   <= 1'b0;
      ord_q   <= 1'b0;
      oack_q  <= {NPORTS{1'b0}};
`ifdef SDRAM_ARB_REFRESH_EN
      oref_q  <= 1'b0;
`endif
      case (state_q)
        // First cycle out of reset raises the pulse, second cycle moves on
        S_INIT_REQ: begin
          if (!armed_q) begin
            armed_q <= 1'b1;
            oinit_q <= 1'b1;
          end else begin
            state_q <= S_INIT_WAIT;
          end
        end
        S_INIT_WAIT: begin
          if (iinit_fin) begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
`ifdef SDRAM_ARB_REFRESH_EN
          if (ref_pending_q) begin
            state_q <= S_REF_ISSUE;
            oref_q  <= 1'b1;
            osel_q  <= SEL_REF;
          end else
`endif
          if (gnt_valid_s) begin
            state_q  <= S_ISSUE;
            last_q   <= gnt_idx_s;
            dir_we_q <= iwe[gnt_idx_s];
            oaddr_q  <= iaddr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
            owdata_q <= iwdata[int'(gnt_idx_s)*DATA_W +: DATA_W];
            owr_q    <= iwe[gnt_idx_s];
            ord_q    <= !iwe[gnt_idx_s];
            osel_q   <= iwe[gnt_idx_s] ? SEL_WR : SEL_RD;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (dir_we_q ? iwr_fin : ird_fin) begin
            state_q        <= S_ACK;
            oack_q[last_q] <= 1'b1;
            if (!dir_we_q) begin
              ordata_q <= ird_data;
            end
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          osel_q  <= SEL_INIT;
        end
`ifdef SDRAM_ARB_REFRESH_EN
        S_REF_ISSUE: begin
          state_q <= S_REF_WAIT;
        end
        S_REF_WAIT: begin
          if (iref_fin) begin
            state_q <= S_IDLE;
            osel_q  <= SEL_INIT;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          osel_q  <= SEL_INIT;
        end
      endcase
    end
  end

  assign oack      = oack_q;
  assign ordata    = ordata_q;
  assign oinit_req = oinit_q;
  assign owr_req   = owr_q;
  assign ord_req   = ord_q;
  assign osel      = osel_q;
  assign oaddr     = oaddr_q;
  assign owdata    = owdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: reset/init handshake, round-robin order,
// a table of single transactions, reset mid-transaction and refresh (or its absence).
module tb_sdram_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 25;
  localparam int DW = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     ireq = '0;
  logic [NP-1:0]     iwe = '0;
  logic [NP*AW-1:0]  iaddr = '0;
  logic [NP*DW-1:0]  iwdata = '0;
  logic [NP-1:0]     oack;
  logic [DW-1:0]     ordata;
  logic              oinit_req, owr_req, ord_req, oref_req;
  logic [3:0]        osel;
  logic [AW-1:0]     oaddr;
  logic [DW-1:0]     owdata;
  logic              iinit_fin = 1'b0;
  logic              iwr_fin = 1'b0;
  logic              ird_fin = 1'b0;
  logic              iref_fin = 1'b0;
  logic [DW-1:0]     ird_data = '0;

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [3:0]    exp_osel;
    logic [DW-1:0] exp_ordata;
  } txn_t;

  txn_t          vecs[6];
  txn_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  int            eng_lat = 3;
  int            eng_cnt = 0;
  logic          eng_wr = 1'b0;
  int            ref_cnt = 0;
  logic [DW-1:0] rd_pattern = '0;

  sdram_port_arbiter #(
    .NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .REFRESH_INTERVAL(16)
  ) dut (
    .iclk(clk), .ireset_n(rst_n), .ireq(ireq), .iwe(iwe), .iaddr(iaddr), .iwdata(iwdata),
    .oack(oack), .ordata(ordata), .oinit_req(oinit_req), .owr_req(owr_req), .ord_req(ord_req),
    .oref_req(oref_req), .osel(osel), .oaddr(oaddr), .owdata(owdata), .iinit_fin(iinit_fin),
    .iwr_fin(iwr_fin), .ird_fin(ird_fin), .iref_fin(iref_fin), .ird_data(ird_data)
  );

  always #5 clk = ~clk;

  // Engine model: finishes eng_lat cycles after a start pulse, with a decoy
  // strobe of the opposite direction one cycle earlier.
  always @(negedge clk) begin
    iwr_fin  = 1'b0;
    ird_fin  = 1'b0;
    iref_fin = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 1) begin
        if (eng_wr) begin
          ird_fin  = 1'b1;
          ird_data = ~rd_pattern;
        end else begin
          iwr_fin = 1'b1;
        end
      end else if (eng_cnt == 0) begin
        if (eng_wr) begin
          iwr_fin = 1'b1;
        end else begin
          ird_fin  = 1'b1;
          ird_data = rd_pattern;
        end
      end
    end
    if (owr_req || ord_req) begin
      eng_cnt = eng_lat;
      eng_wr  = owr_req;
    end
    if (ref_cnt > 0) begin
      ref_cnt = ref_cnt - 1;
      if (ref_cnt == 0) iref_fin = 1'b1;
    end
    if (oref_req) ref_cnt = 3;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    ireq = '0;
    iinit_fin = 1'b0;
    sb_q.delete();
    #1;
    chk({name, "_oack"}, DW'(oack), DW'(0));
    chk({name, "_pulses"}, DW'({oinit_req, owr_req, ord_req, oref_req}), DW'(0));
    chk({name, "_osel"}, DW'(osel), DW'(4'b0001));
    chk({name, "_oaddr"}, DW'(oaddr), DW'(0));
    chk({name, "_owdata"}, owdata, DW'(0));
    chk({name, "_ordata"}, ordata, DW'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic init_seq(input string name);
    int seen = 0;
    int bad = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (oinit_req) seen = 1;
      else if (owr_req || ord_req || oref_req || (|oack)) bad++;
    end
    chk({name, "_init_pulse"}, DW'(seen), DW'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (oinit_req || owr_req || ord_req || oref_req || (|oack) || osel != 4'b0001) bad++;
    end
    iinit_fin = 1'b1;
    @(negedge clk);
    iinit_fin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (oinit_req || owr_req || ord_req || oref_req || (|oack) || osel != 4'b0001) bad++;
    end
    chk({name, "_init_quiet"}, DW'(bad), DW'(0));
  endtask

  // Pops the scoreboard head when the DUT acknowledges and checks the transaction
  task automatic wait_ack(input string name);
    int n_ok = 0;
    int n_bad = 0;
    logic got = 1'b0;
    txn_t t;
    logic [NP-1:0] exp_ack;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard_empty actual=0 required=1", name);
      return;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if ((owr_req && sb_q[0].we) || (ord_req && !sb_q[0].we)) n_ok++;
      else if (owr_req || ord_req) n_bad++;
      if (|oack) begin
        got = 1'b1;
        t = sb_q.pop_front();
        exp_ack = NP'(1) << t.port;
        chk({name, "_oack"}, DW'(oack), DW'(exp_ack));
        chk({name, "_oaddr"}, DW'(oaddr), DW'(t.addr));
        chk({name, "_osel"}, DW'(osel), DW'(t.exp_osel));
        chk({name, "_ordata"}, ordata, t.exp_ordata);
        if (t.we) chk({name, "_owdata"}, owdata, t.wdata);
        chk({name, "_issue_pulse"}, DW'(n_ok * 10 + n_bad), DW'(10));
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s ack_timeout actual=none required=port%0d", name, sb_q[0].port);
      void'(sb_q.pop_front());
    end else begin
      @(negedge clk);
      chk({name, "_ack_one_cycle"}, DW'(oack), DW'(0));
    end
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    iaddr[p*AW +: AW]  = a;
    iwdata[p*DW +: DW] = d;
    iwe[p]             = we;
  endtask

  initial begin
    logic [DW-1:0] rr_rd;
    txn_t t;
    int seen;

    vecs[0] = '{2, 1'b0, 25'h0ABCDEF, 128'h0,
                128'hDEADBEEF_CAFEF00D_12345678_000055AA, 4'b0100,
                128'hDEADBEEF_CAFEF00D_12345678_000055AA};
    vecs[1] = '{0, 1'b1, 25'h1FFFFFF, {128{1'b1}}, 128'h1111, 4'b0010,
                128'hDEADBEEF_CAFEF00D_12345678_000055AA};
    vecs[2] = '{3, 1'b1, 25'h0000000, {32{4'hA}}, 128'h2222, 4'b0010,
                128'hDEADBEEF_CAFEF00D_12345678_000055AA};
    vecs[3] = '{1, 1'b0, 25'h1555555, 128'h0, 128'h1, 4'b0100, 128'h1};
    vecs[4] = '{3, 1'b0, 25'h0000001, 128'h0, {128{1'b1}}, 4'b0100, {128{1'b1}}};
    vecs[5] = '{2, 1'b1, 25'h1234567, 128'h0, 128'h3333, 4'b0010, {128{1'b1}}};

    apply_reset("reset0");
    init_seq("boot0");

    // All four ports request together: expect 0,1,2,3 then port 0 again
    rr_rd = 128'h0000C0DE_0000C0DE_0000C0DE_0000C0DE;
    rd_pattern = rr_rd;
    for (int p = 0; p < NP; p++) begin
      set_port(p, (p % 2) == 1, AW'(25'h100000 + p), {4{32'(p + 16)}});
    end
    for (int n = 0; n < 5; n++) begin
      t.port = n % NP;
      t.we = (t.port % 2) == 1;
      t.addr = AW'(25'h100000 + t.port);
      t.wdata = {4{32'(t.port + 16)}};
      t.rdata = rr_rd;
      t.exp_osel = t.we ? 4'b0010 : 4'b0100;
      t.exp_ordata = rr_rd;
      sb_q.push_back(t);
    end
    ireq = 4'b1111;
    for (int n = 0; n < 5; n++) wait_ack($sformatf("rr%0d", n));
    ireq = '0;

    for (int v = 0; v < 6; v++) begin
      set_port(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      rd_pattern = vecs[v].rdata;
      ireq[vecs[v].port] = 1'b1;
      sb_q.push_back(vecs[v]);
      wait_ack($sformatf("vec%0d", v));
      ireq = '0;
    end

    // Reset while port 1's read is in flight, then port 0 must win over port 2
    eng_lat = 8;
    set_port(1, 1'b0, 25'h0777777, 128'h0);
    rd_pattern = 128'h4444;
    ireq[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (ord_req) seen = 1;
    end
    chk("midrst_issue_seen", DW'(seen), DW'(1));
    apply_reset("midrst");
    eng_lat = 3;
    init_seq("boot1");
    set_port(0, 1'b1, 25'h0000100, 128'h5A5A);
    set_port(2, 1'b1, 25'h0000200, 128'hA5A5);
    sb_q.push_back('{0, 1'b1, 25'h0000100, 128'h5A5A, 128'h0, 4'b0010, 128'h0});
    sb_q.push_back('{2, 1'b1, 25'h0000200, 128'hA5A5, 128'h0, 4'b0010, 128'h0});
    ireq = 4'b0101;
    wait_ack("post_rst_a");
    wait_ack("post_rst_b");
    ireq = '0;

`ifdef SDRAM_ARB_REFRESH_EN
    // Refresh falls due while port 1 is busy; it must precede waiting port 3
    apply_reset("reset2");
    init_seq("boot2");
    eng_lat = 30;
    rd_pattern = 128'h6666;
    set_port(1, 1'b0, 25'h0010001, 128'h0);
    set_port(3, 1'b1, 25'h0030003, 128'h7777);
    sb_q.push_back('{1, 1'b0, 25'h0010001, 128'h0, 128'h6666, 4'b0100, 128'h6666});
    sb_q.push_back('{3, 1'b1, 25'h0030003, 128'h7777, 128'h6666, 4'b0010, 128'h6666});
    ireq = 4'b1010;
    wait_ack("ref_p1");
    @(negedge clk);
    chk("ref_after_ack", DW'(oref_req), DW'(1));
    chk("ref_osel", DW'(osel), DW'(4'b1000));
    wait_ack("ref_p3");
    ireq = '0;
    eng_lat = 3;
`else
    begin
      int nref = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (oref_req || osel[3]) nref++;
      end
      chk("no_refresh", DW'(nref), DW'(0));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
